// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - control bundle layout and default bubble squash mask
package ctrl_pkg;

  localparam int CTRL_W = 17;

  // Bundle layout, MSB first: RegWrite, MemWrite, MemRead, ALUSrc, ResultSrc[1:0],
  // Branch, Jump, JumpReg, ImmType[2:0], ALUControl[4:0]
  localparam int REGWRITE_B    = 16;
  localparam int MEMWRITE_B    = 15;
  localparam int MEMREAD_B     = 14;
  localparam int ALUSRC_B      = 13;
  localparam int RESULTSRC_LSB = 11;
  localparam int BRANCH_B      = 10;
  localparam int JUMP_B        = 9;
  localparam int JUMPREG_B     = 8;
  localparam int IMMTYPE_LSB   = 5;
  localparam int ALUCTRL_LSB   = 0;

  localparam logic [CTRL_W-1:0] SQUASH_MASK_DFLT = {CTRL_W{1'b1}};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Holds at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ctrl_bubble_reg.sv
// rtl/ctrl_bubble_reg.sv - ID/EX control register with bubble trains, flush and stall hold
module ctrl_bubble_reg
  import ctrl_pkg::*;
#(
  parameter int                CTRL_W      = ctrl_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0] SQUASH_MASK = {CTRL_W{1'b1}},
  parameter int                MAX_BUBBLES = 3,
  parameter int                CNT_W       = $clog2(MAX_BUBBLES + 1),
  parameter int                STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble_req,
  input  logic [CNT_W-1:0]  bubble_len,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              hold_up,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [STAT_W-1:0] bubble_total
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BUBBLES);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] bubble_word;
  logic [CNT_W-1:0]  len_clamped;
  logic              accept;
  logic              load_bubble;

  assign bubble_word = ctrl_in & ~SQUASH_MASK;
  assign accept      = bubble_req & ~flush & ~stall & (cnt_q == '0);

  always_comb begin
    len_clamped = bubble_len;
    if (bubble_len == '0) begin
      len_clamped = CNT_W'(1);
    end else if (bubble_len > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  // Flush beats stall; a running train ignores new requests until it drains.
  always_comb begin
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    load_bubble = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
      cnt_d       = '0;
    end else if (stall) begin
      load_bubble = 1'b0;
    end else if (cnt_q != '0) begin
      load_bubble = 1'b1;
      cnt_d       = cnt_q - CNT_W'(1);
    end else if (accept) begin
      load_bubble = 1'b1;
      cnt_d       = len_clamped - CNT_W'(1);
    end else begin
      ctrl_d  = ctrl_in;
      valid_d = valid_in;
    end
    if (load_bubble) begin
      ctrl_d  = bubble_word;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hold_up    = ~flush & (bubble_req | (cnt_q != '0));
  assign ctrl_out   = ctrl_q;
  assign valid_out  = valid_q;
  assign bubble_cnt = cnt_q;

  sat_counter #(
    .W(STAT_W)
  ) u_bubble_stat (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (load_bubble),
    .clear(1'b0),
    .count(bubble_total)
  );

endmodule

// File: doc/ctrl_bubble_reg.md
Name: ctrl_bubble_reg

Overview:
- Parametrised ID/EX control-bundle pipeline register that inserts bubbles.
- It generalises the single-cycle combinational control zeroing to four features:
  - a programmable squash mask;
  - multi-cycle bubble trains (load-use, multicycle ALU);
  - flush with cancellation of pending bubbles;
  - downstream stall hold.
- Sits between decode/control and the EX stage. Produces an upstream hold signal for the PC/IF-ID registers and a saturating bubble statistic.

Parameters:
- CTRL_W, 17, width of the control bundle (RegWrite..ALUControl packing from ctrl_pkg).
- SQUASH_MASK, {CTRL_W{1'b1}}, bits forced to 0 in a bubble. Bits with mask=0 pass ctrl_in through unchanged.
- MAX_BUBBLES, 3, longest bubble train; must be >=1.
- CNT_W, $clog2(MAX_BUBBLES+1), width of bubble_len and bubble_cnt.
- STAT_W, 16, width of the bubble statistic counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- ctrl_in, input, CTRL_W, control bundle from decode.
- valid_in, input, 1, decode slot holds a real instruction.
- stall, input, 1, downstream hold; register and counter freeze.
- flush, input, 1, kill the slot (branch/jump redirect).
- bubble_req, input, 1, level request for a bubble train; held until accepted.
- bubble_len, input, CNT_W, train length; 0 is treated as 1; values >MAX_BUBBLES are clamped to MAX_BUBBLES.
- ctrl_out, output, CTRL_W, registered bundle to EX.
- valid_out, output, 1, registered valid.
- hold_up, output, 1, combinational freeze request to PC/IF-ID.
- bubble_cnt, output, CNT_W, remaining bubbles after the current one.
- bubble_total, output, STAT_W, saturating count of bubble cycles inserted.

Behaviour:
- Reset (rst_n=0, asynchronous): ctrl_out=0, valid_out=0, bubble_cnt=0, bubble_total=0. hold_up follows its combinational equation. Release is synchronous to clk.
- Bubble word: bw = ctrl_in & ~SQUASH_MASK. Loading a bubble sets ctrl_out<=bw and valid_out<=0.
- accept = bubble_req & ~flush & ~stall & (bubble_cnt==0).
- Per-edge priority, highest first:
  1. flush: load bubble; bubble_cnt<=0, cancelling any pending train; any bubble_req this cycle is dropped. Flush overrides stall.
  2. stall: ctrl_out, valid_out and bubble_cnt hold; bubble_total unchanged.
  3. bubble_cnt!=0: load bubble; bubble_cnt<=bubble_cnt-1. bubble_req is ignored and never extends the train.
  4. accept: load bubble; bubble_cnt<=clamp(len)-1, where clamp(len)=max(1,min(bubble_len,MAX_BUBBLES)).
  5. Otherwise: ctrl_out<=ctrl_in, valid_out<=valid_in.
- hold_up = ~flush & (bubble_req | bubble_cnt!=0). Upstream therefore freezes for exactly clamp(len) cycles per accepted train, plus any stall cycles in between.
- bubble_total increments by 1 on every edge that loads a bubble (flush, train or accept). It saturates at 2^STAT_W-1 with no wrap.
- Latency: one cycle from ctrl_in to ctrl_out.
- Simultaneous events:
  - flush+stall: flush wins.
  - stall+bubble_req with cnt==0: not accepted; hold_up=1 and the request is retried next cycle.
  - Reset mid-train: counter cleared, no residual bubbles.
- With the default mask and MAX_BUBBLES=1, behaviour equals a plain register behind an all-zero control mux.

Decomposition:
- ctrl_pkg holds:
  - the CTRL_W constant;
  - field offsets (REGWRITE_B, MEMWRITE_B, MEMREAD_B, ALUSRC_B, RESULTSRC_LSB, BRANCH_B, JUMP_B, JUMPREG_B, IMMTYPE_LSB, ALUCTRL_LSB);
  - the default SQUASH_MASK localparam.
- One sub-module, sat_counter (parameter W, ports inc and clear), implements bubble_total. Everything else is inline.

Test Plan:
1. Reset then pass-through: ctrl_in=17'h1ABCD, valid_in=1 -> the next edge gives ctrl_out=17'h1ABCD, valid_out=1, hold_up=0.
2. bubble_req=1, bubble_len=2, no stall -> two edges load ctrl_out=0, valid_out=0, bubble_cnt goes 1 then 0. hold_up=1 for 2 cycles. bubble_total=2. Third edge passes ctrl_in.
3. Stall mid-train: len=3, stall on the 2nd cycle -> bubble_cnt holds at 2 for that cycle, total 3 bubble cycles, hold_up high for 4 cycles, bubble_total=3.
4. Flush during a train (cnt=2) with bubble_req=1 -> bubble loaded, bubble_cnt=0, hold_up=0 that cycle; normal loading resumes the next edge.
5. SQUASH_MASK=17'h1FFE0 (keep ALUControl), ctrl_in=17'h1FF15, bubble -> ctrl_out=17'h00015, valid_out=0.
6. bubble_len=0 -> one bubble. bubble_len=7 with MAX_BUBBLES=3 -> three bubbles. With STAT_W=2, five bubbles -> bubble_total=3 (saturated). Async reset mid-train -> all outputs 0 immediately.
